// File: rtl/multicycle_control.sv
// Multicycle main control FSM for an RV32I subset (add/sub/and/or/srl/lw/lb/sw/beq/ori).
// The state register is the only storage; all strobes are decoded from it and gated by mem_ready where needed.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op1,
  output logic       alu_op0,
  output logic       funct_zero,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       load_byte,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd15
  } state_e;

  state_e state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= S_MEM_ADDR;
            OP_R:              state_q <= S_EXEC_R;
            OP_IARITH:         state_q <= S_EXEC_I;
            OP_BRANCH:         state_q <= S_BRANCH;
            default:           state_q <= S_HALT;
          endcase
        end
        S_MEM_ADDR:  state_q <= (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXEC_R,
        S_EXEC_I:    state_q <= S_ALU_WB;
        S_ALU_WB,
        S_BRANCH:    state_q <= S_FETCH;
        default:     state_q <= S_HALT;
      endcase
    end
  end

  assign state = state_q;

  // Reset overrides the decode so an abandoned instruction cannot strobe a write.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op1       = 1'b0;
    alu_op0       = 1'b0;
    funct_zero    = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    load_byte     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b01;
          funct_zero = 1'b1;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b10;
          funct_zero = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          funct_zero = 1'b1;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          load_byte  = (funct3 == 3'b000);
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b01;
          alu_op1   = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b01;
          alu_op0       = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
          instr_done    = 1'b1;
        end
        S_HALT:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks R, lb, sw, ori, beq, fetch stall, illegal opcode and mid-store reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source;
  logic [1:0] alu_src_a, alu_src_b;
  logic       alu_op1, alu_op0, funct_zero, reg_write, mem_to_reg, load_byte, instr_done, illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1), .alu_op0(alu_op0),
    .funct_zero(funct_zero), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .load_byte(load_byte), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Every output except state, illegal in bit 0.
  function automatic logic [18:0] outs();
    return {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
            alu_src_a, alu_src_b, alu_op1, alu_op0, funct_zero, reg_write, mem_to_reg,
            load_byte, instr_done, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_IA = 7'b0010011;

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'b000;
    nxt(); #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'(outs()), 0);
    nxt(); #1;
    chk("rst_outs2", 32'(outs()), 0);

    // R-type: 0,1,6,8,0
    reset = 1'b0; #1;
    chk("r_s0", 32'(state), 0);
    chk("r_fetch_ir", 32'({mem_req, iord, ir_write, pc_write, funct_zero}), 32'b10111);
    chk("r_fetch_srcb", 32'(alu_src_b), 1);
    nxt(); #1;
    chk("r_s1", 32'(state), 1);
    chk("r_dec_src", 32'({alu_src_a, alu_src_b}), 32'b1010);
    nxt(); #1;
    chk("r_s6", 32'(state), 6);
    chk("r_exec", 32'({alu_op1, alu_op0, alu_src_b, reg_write}), 32'b10000);
    nxt(); #1;
    chk("r_s8", 32'(state), 8);
    chk("r_wb", 32'({reg_write, mem_to_reg, instr_done}), 32'b101);

    // lb with three stalled read cycles
    nxt(); opcode = OP_LOAD; funct3 = 3'b000; #1;
    chk("lb_s0", 32'(state), 0);
    chk("lb_done_low", 32'(instr_done), 0);
    nxt(); #1; chk("lb_s1", 32'(state), 1);
    nxt(); #1; chk("lb_s2", 32'(state), 2);
    chk("lb_addr", 32'({alu_src_a, alu_src_b, funct_zero}), 32'b01101);
    nxt(); mem_ready = 1'b0; #1;
    chk("lb_s3a", 32'(state), 3);
    chk("lb_read", 32'({mem_req, mem_write, iord, instr_done}), 32'b1010);
    nxt(); #1; chk("lb_s3b", 32'(state), 3);
    nxt(); #1; chk("lb_s3c", 32'(state), 3);
    nxt(); mem_ready = 1'b1; #1; chk("lb_s3d", 32'(state), 3);
    nxt(); #1;
    chk("lb_s4", 32'(state), 4);
    chk("lb_wb", 32'({reg_write, mem_to_reg, load_byte, instr_done}), 32'b1111);

    // sw
    nxt(); opcode = OP_STORE; funct3 = 3'b010; #1;
    chk("sw_s0", 32'(state), 0);
    chk("sw_rw0", 32'(reg_write), 0);
    nxt(); #1; chk("sw_s1", 32'(state), 1); chk("sw_rw1", 32'(reg_write), 0);
    nxt(); #1; chk("sw_s2", 32'(state), 2); chk("sw_rw2", 32'(reg_write), 0);
    nxt(); #1;
    chk("sw_s5", 32'(state), 5);
    chk("sw_wr", 32'({mem_req, mem_write, iord, instr_done, reg_write}), 32'b11110);
    nxt(); #1; chk("sw_back", 32'(state), 0);

    // ori: funct must reach the decoder only in EXEC_I
    opcode = OP_IA; funct3 = 3'b110; #1;
    chk("ori_fz0", 32'(funct_zero), 1);
    nxt(); #1; chk("ori_s1", 32'(state), 1); chk("ori_fz1", 32'(funct_zero), 1);
    nxt(); #1;
    chk("ori_s7", 32'(state), 7);
    chk("ori_exec", 32'({funct_zero, alu_op1, alu_op0, alu_src_a, alu_src_b}), 32'b0000110);
    chk("ori_lb", 32'(load_byte), 0);
    nxt(); #1; chk("ori_s8", 32'(state), 8);
    nxt(); #1; chk("ori_back", 32'(state), 0);

    // beq
    opcode = OP_BR; funct3 = 3'b000;
    nxt(); #1; chk("beq_s1", 32'(state), 1);
    nxt(); #1;
    chk("beq_s9", 32'(state), 9);
    chk("beq_br", 32'({pc_write_cond, pc_source, alu_op1, alu_op0, pc_write, instr_done}), 32'b110101);
    nxt(); #1; chk("beq_back", 32'(state), 0);

    // fetch stall for 4 cycles
    mem_ready = 1'b0; #1;
    chk("stall_strobe0", 32'({ir_write, pc_write, mem_req}), 32'b001);
    for (int i = 1; i < 4; i++) begin
      nxt(); #1;
      chk("stall_state", 32'(state), 0);
      chk("stall_strobe", 32'({ir_write, pc_write}), 0);
    end
    nxt(); mem_ready = 1'b1; opcode = 7'b1111111; #1;
    chk("stall_release", 32'({state, ir_write, pc_write}), 32'b000011);

    // illegal opcode halts
    nxt(); #1; chk("ill_s1", 32'(state), 1);
    for (int i = 0; i < 10; i++) begin
      nxt(); mem_ready = 1'($urandom_range(0, 1)); #1;
      chk("ill_state", 32'(state), 15);
      chk("ill_outs", 32'(outs()), 1);
    end

    // reset recovers from HALT
    reset = 1'b1; #1;
    chk("rst_halt_outs", 32'(outs()), 0);
    nxt(); reset = 1'b0; opcode = OP_STORE; mem_ready = 1'b1; #1;
    chk("rst_halt_state", 32'(state), 0);
    chk("rst_halt_ill", 32'(illegal), 0);

    // reset during a stalled MEM_WRITE
    nxt(); #1; chk("rw_s1", 32'(state), 1);
    nxt(); #1; chk("rw_s2", 32'(state), 2);
    nxt(); mem_ready = 1'b0; #1;
    chk("rw_s5", 32'(state), 5);
    chk("rw_mw", 32'(mem_write), 1);
    reset = 1'b1; #1;
    chk("rw_mw_rst", 32'(mem_write), 0);
    chk("rw_outs_rst", 32'(outs()), 0);
    nxt(); #1;
    chk("rw_state_rst", 32'(state), 0);
    chk("rw_outs_rst2", 32'(outs()), 0);
    reset = 1'b0; #1;
    chk("rw_after", 32'({state, illegal, mem_write}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control FSM for the RV32I subset: add, sub, and, or, srl, lw, lb, sw, beq, ori.
- Sits directly upstream of the ALU control decoder. It produces alu_op1/alu_op0 and a funct-zeroing strobe for that decoder, plus every datapath and memory strobe.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Handles a ready/request handshake with the unified instruction/data memory.

Parameters:
- none. Opcodes are fixed: R=0110011, LOAD=0000011, STORE=0100011, BRANCH=1100011, IARITH=0010011.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- opcode  input  7  instruction register bits [6:0]
- funct3  input  3  instruction register bits [14:12]
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  1 means write, 0 means read (valid with mem_req)
- iord  output  1  address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  load the instruction register
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_source  output  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  output  2  A operand: 00 = PC, 01 = rs1, 10 = oldPC
- alu_src_b  output  2  B operand: 00 = rs2, 01 = constant 4, 10 = immediate
- alu_op1, alu_op0  output  1 each  to the ALU control decoder
- funct_zero  output  1  datapath forces the decoder funct input to 4'b0000
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- load_byte  output  1  sign-extend byte for lb
- instr_done  output  1  one-cycle pulse on the last cycle of an instruction
- illegal  output  1  sticky: FSM halted on an unknown opcode
- state  output  4  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, HALT=15.
- Reset:
  - Sampled on the clock edge; state goes to FETCH and illegal clears.
  - While reset is high, every output except state is forced to 0.
  - Reset mid-instruction abandons it. No write strobes are issued in that cycle or after it.
- Outputs are decoded from state. ir_write and pc_write in FETCH, and instr_done in memory states, are additionally gated by mem_ready. Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, ALUOp=00, funct_zero=1. When mem_ready=1, also ir_write=1 and pc_write=1, and the next state is DECODE. Otherwise stay in FETCH with no strobes.
  - DECODE: alu_src_a=10, alu_src_b=10, ALUOp=00, funct_zero=1 (branch target into ALUOut). Next state by opcode: LOAD or STORE → MEM_ADDR; R → EXEC_R; IARITH → EXEC_I; BRANCH → BRANCH; anything else → HALT.
  - MEM_ADDR: alu_src_a=01, alu_src_b=10, ALUOp=00, funct_zero=1. Next: LOAD → MEM_READ, STORE → MEM_WRITE.
  - MEM_READ: mem_req=1, iord=1, mem_write=0. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, load_byte=(funct3==000), instr_done=1. Next: FETCH.
  - MEM_WRITE: mem_req=1, mem_write=1, iord=1. When mem_ready=1, instr_done=1 and the next state is FETCH.
  - EXEC_R: alu_src_a=01, alu_src_b=00, ALUOp=10. Next: ALU_WB.
  - EXEC_I: alu_src_a=01, alu_src_b=10, ALUOp=00, funct_zero=0, so funct3=110 reaches the decoder and selects OR. Next: ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=01, alu_src_b=00, ALUOp=01, pc_write_cond=1, pc_source=1, instr_done=1. Next: FETCH.
  - HALT: illegal=1 and all strobes are 0. Leaves only through reset.
- Cycle counts with mem_ready tied to 1: lw/lb 5, sw 4, R-type/ori 4, beq 3. Each mem_ready=0 cycle in a memory state adds one cycle.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- funct3 affects only load_byte. The decoder sees funct3 through the datapath, gated by funct_zero.
- ALUOp value 11 is never driven.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=0110011 → state sequence 0,1,6,8,0. In state 6: ALUOp=10, alu_src_b=00. In state 8: reg_write=1 and instr_done=1 for one cycle.
- lb (opcode 0000011, funct3 000), with mem_ready=0 for 3 cycles in MEM_READ → sequence 0,1,2,3,3,3,3,4 (8 cycles). In state 4: load_byte=1, mem_to_reg=1.
- sw (0100011) with mem_ready=1 → sequence 0,1,2,5,0. In state 5: mem_write=1, iord=1, instr_done=1. reg_write stays 0 throughout.
- ori (0010011, funct3 110) → funct_zero=1 in states 0, 1 and 2 (where applicable), and funct_zero=0 with ALUOp=00, alu_src_b=10 in EXEC_I. beq (1100011) → state 9 with pc_write_cond=1, ALUOp=01.
- FETCH with mem_ready=0 for 4 cycles → ir_write=0 and pc_write=0 throughout, state stays 0. Both pulse on the first ready cycle.
- opcode=1111111 in DECODE → state 15, illegal=1 held for 10 cycles with no strobes. Reset asserted during MEM_WRITE → no mem_write while reset is high, state=0 afterwards, illegal=0.
